// File: rtl/bist_datapath_if.sv
// BIST responder bus: controller handshake in, CUT pattern and results out.
// Optional BIST_FAULT_INJECT_EN adds a fault_inject input used to corrupt
// the MISR input so the compare path can be exercised.
interface bist_datapath_if #(
  parameter int LFSR_W = 16,
  parameter int PAT_W  = 8,
  parameter int RESP_W = 8,
  parameter int CNT_W  = 16
);
  logic              init;
  logic              running;
  logic              toggle;
  logic              finish;
  logic [RESP_W-1:0] cut_resp;
`ifdef BIST_FAULT_INJECT_EN
  logic              fault_inject;
`endif
  logic [PAT_W-1:0]  pattern;
  logic              pattern_valid;
  logic [LFSR_W-1:0] signature;
  logic [CNT_W-1:0]  pat_count;
  logic              done;
  logic              pass;
  logic              proto_err;

  // Controller / test-harness side.
  modport master (
    output init, running, toggle, finish, cut_resp,
`ifdef BIST_FAULT_INJECT_EN
    output fault_inject,
`endif
    input  pattern, pattern_valid, signature, pat_count, done, pass, proto_err
  );

  // Datapath (responder) side.
  modport slave (
    input  init, running, toggle, finish, cut_resp,
`ifdef BIST_FAULT_INJECT_EN
    input  fault_inject,
`endif
    output pattern, pattern_valid, signature, pat_count, done, pass, proto_err
  );
endinterface

// File: rtl/bist_datapath.sv
// BIST datapath responder. A Galois LFSR generates CUT patterns, a MISR with
// the same feedback mask compacts CUT responses, and on finish the signature
// is compared with GOLDEN_SIG; done/pass stay latched until init or reset.
// Optional feature macro: BIST_FAULT_INJECT_EN (adds fault_inject, which flips
// bit 0 of the word folded into the MISR during a compression cycle).
module bist_datapath #(
  parameter int                LFSR_W     = 16,
  parameter int                PAT_W      = 8,    // must be <= LFSR_W
  parameter int                RESP_W     = 8,    // must be <= LFSR_W
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1, // must be nonzero
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] GOLDEN_SIG = 16'h0000,
  parameter int                CNT_W      = 16
) (
  input  logic     clk,
  input  logic     reset,
  bist_datapath_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_e;

  state_e            state_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] misr_q, misr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, pass_q, err_q;
  logic [LFSR_W-1:0] resp_ext;
  logic              active;
  logic              compress;

  // One Galois shift: LSB out, feedback mask applied when it was set.
  function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] x);
    step = x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  // Response word folded into the MISR, optionally with bit 0 corrupted.
`ifdef BIST_FAULT_INJECT_EN
  assign resp_ext = LFSR_W'(bus.cut_resp) ^ LFSR_W'(bus.fault_inject);
`else
  assign resp_ext = LFSR_W'(bus.cut_resp);
`endif

  // A pattern is compressed only when running wins the priority order in a
  // state that accepts patterns.
  assign active   = (state_q == ARMED) || (state_q == RUN);
  assign compress = bus.running & active & ~bus.init & ~bus.finish;

  // Next-state values used on a compression cycle; the counter saturates.
  always_comb begin
    lfsr_d = step(lfsr_q);
    misr_d = step(misr_q) ^ resp_ext;
    cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Control FSM and all datapath registers; priority reset > init > finish > running.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.init) begin
      state_q <= ARMED;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.finish) begin
      unique case (state_q)
        RUN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          pass_q  <= (misr_q == GOLDEN_SIG);
        end
        IDLE, ARMED: err_q <= 1'b1;
        default: ;  // finish in DONE is ignored
      endcase
    end else if (bus.running) begin
      if (active) begin
        state_q <= RUN;
        lfsr_q  <= lfsr_d;
        misr_q  <= misr_d;
        cnt_q   <= cnt_d;
      end else begin
        err_q   <= 1'b1;
      end
    end
  end

  // Pattern is shown combinationally from the LFSR; toggle never alters the sequence.
  assign bus.pattern       = bus.toggle ? ~lfsr_q[PAT_W-1:0] : lfsr_q[PAT_W-1:0];
  assign bus.pattern_valid = compress;
  assign bus.signature     = misr_q;
  assign bus.pat_count     = cnt_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.proto_err     = err_q;

endmodule

// File: tb/tb_bist_datapath.sv
// Directed bench for bist_datapath with a scoreboard queue: expected values are
// pushed as stimulus is applied and popped/compared once the DUT has responded.
module tb_bist_datapath;

  localparam int LFSR_W = 16;
  localparam int PAT_W  = 8;
  localparam int RESP_W = 8;
  localparam int CNT_W  = 16;

  typedef enum {S_PAT, S_PV, S_SIG, S_CNT, S_DONE, S_PASS, S_ERR} sig_e;
  typedef struct {
    sig_e        sel;
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  bist_datapath_if #(.LFSR_W(LFSR_W), .PAT_W(PAT_W), .RESP_W(RESP_W), .CNT_W(CNT_W)) bus ();

  bist_datapath #(
    .LFSR_W(LFSR_W), .PAT_W(PAT_W), .RESP_W(RESP_W),
    .LFSR_SEED(16'hACE1), .TAPS(16'hB400), .GOLDEN_SIG(16'hB400), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_PAT:   return 32'(bus.pattern);
      S_PV:    return 32'(bus.pattern_valid);
      S_SIG:   return 32'(bus.signature);
      S_CNT:   return 32'(bus.pat_count);
      S_DONE:  return 32'(bus.done);
      S_PASS:  return 32'(bus.pass);
      default: return 32'(bus.proto_err);
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_val(sig_e s, string tag, logic [31:0] v);
    exp_t e;
    e.sel = s; e.tag = tag; e.val = v;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic drive(logic i, logic r, logic t, logic f, logic [RESP_W-1:0] resp);
    bus.init     = i;
    bus.running  = r;
    bus.toggle   = t;
    bus.finish   = f;
    bus.cut_resp = resp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    drive(1, 0, 0, 0, '0);
    tick();
  endtask

  initial begin
`ifdef BIST_FAULT_INJECT_EN
    bus.fault_inject = 1'b0;
`endif
    reset = 1'b1;
    drive(0, 0, 0, 0, '0);
    tick(); tick();
    expect_val(S_SIG,  "rst_sig",  32'h0);
    expect_val(S_CNT,  "rst_cnt",  32'h0);
    expect_val(S_DONE, "rst_done", 32'h0);
    expect_val(S_PASS, "rst_pass", 32'h0);
    expect_val(S_ERR,  "rst_err",  32'h0);
    expect_val(S_PAT,  "rst_pat",  32'hE1);
    drain();
    reset = 1'b0;

    // Single pattern, toggle=0, then a paused cycle.
    do_init();
    drive(0, 1, 0, 0, 8'h01);
    expect_val(S_PAT, "s1_pat", 32'hE1);
    expect_val(S_PV,  "s1_pv",  32'h1);
    drain();
    tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_SIG, "s1_sig", 32'h0001);
    expect_val(S_CNT, "s1_cnt", 32'h1);
    expect_val(S_PAT, "s1_lfsr_pat", 32'h70);
    expect_val(S_PV,  "s1_pv_off", 32'h0);
    drain();
    tick();
    expect_val(S_SIG, "s1_pause_sig", 32'h0001);
    expect_val(S_PAT, "s1_pause_pat", 32'h70);
    drain();

    // Same with toggle=1: inverted pattern, identical LFSR/MISR.
    do_init();
    drive(0, 1, 1, 0, 8'h01);
    expect_val(S_PAT, "s2_pat", 32'h1E);
    drain();
    tick();
    drive(0, 0, 1, 0, '0);
    expect_val(S_SIG, "s2_sig", 32'h0001);
    expect_val(S_CNT, "s2_cnt", 32'h1);
    expect_val(S_PAT, "s2_lfsr_pat", 32'h8F);
    drain();

    // Passing run: 01, 00 -> signature B400 == golden.
    do_init();
    expect_val(S_DONE, "s3_init_done", 32'h0);
    drain();
    drive(0, 1, 0, 0, 8'h01); tick();
    drive(0, 1, 0, 0, 8'h00); tick();
    drive(0, 0, 0, 1, '0);    tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_SIG,  "s3_sig",  32'hB400);
    expect_val(S_DONE, "s3_done", 32'h1);
    expect_val(S_PASS, "s3_pass", 32'h1);
    expect_val(S_CNT,  "s3_cnt",  32'h2);
    drain();

    // Failing run: 03, 00 -> B401.
    do_init();
    expect_val(S_PASS, "s3b_init_pass", 32'h0);
    drain();
    drive(0, 1, 0, 0, 8'h03); tick();
    drive(0, 1, 0, 0, 8'h00); tick();
    drive(0, 0, 0, 1, '0);    tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_SIG,  "s3b_sig",  32'hB401);
    expect_val(S_DONE, "s3b_done", 32'h1);
    expect_val(S_PASS, "s3b_pass", 32'h0);
    drain();

    // Protocol errors: running in IDLE, finish in ARMED.
    reset = 1'b1; tick(); reset = 1'b0;
    drive(0, 1, 0, 0, 8'h5A);
    expect_val(S_PV, "s4_idle_pv", 32'h0);
    drain();
    tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_ERR, "s4_idle_err", 32'h1);
    expect_val(S_SIG, "s4_idle_sig", 32'h0);
    expect_val(S_CNT, "s4_idle_cnt", 32'h0);
    drain();
    do_init();
    expect_val(S_ERR, "s4_init_clr", 32'h0);
    drain();
    drive(0, 0, 0, 1, '0); tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_ERR, "s4_armed_err", 32'h1);
    expect_val(S_SIG, "s4_armed_sig", 32'h0);
    expect_val(S_CNT, "s4_armed_cnt", 32'h0);
    drain();
    do_init();
    expect_val(S_ERR, "s4_init_clr2", 32'h0);
    drain();

    // Mid-run reset after 3 patterns.
    drive(0, 1, 0, 0, 8'h05); tick();
    drive(0, 1, 0, 0, 8'h0A); tick();
    drive(0, 1, 0, 0, 8'h0F); tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_SIG, "s5_run_sig", 32'h5A0B);
    expect_val(S_CNT, "s5_run_cnt", 32'h3);
    drain();
    reset = 1'b1; tick(); reset = 1'b0;
    expect_val(S_SIG,  "s5_rst_sig",  32'h0);
    expect_val(S_CNT,  "s5_rst_cnt",  32'h0);
    expect_val(S_DONE, "s5_rst_done", 32'h0);
    drain();
    drive(0, 1, 0, 0, 8'h01);
    expect_val(S_PV,  "s5_idle_pv",  32'h0);
    expect_val(S_PAT, "s5_idle_pat", 32'hE1);
    drain();
    tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_ERR, "s5_idle_err", 32'h1);
    drain();

    // Init while DONE clears done/pass.
    do_init();
    drive(0, 1, 0, 0, 8'h01); tick();
    drive(0, 1, 0, 0, 8'h00); tick();
    drive(0, 0, 0, 1, '0);    tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_PASS, "s5_done_pass", 32'h1);
    drain();
    do_init();
    expect_val(S_DONE, "s5_reinit_done", 32'h0);
    expect_val(S_PASS, "s5_reinit_pass", 32'h0);
    drain();

    // running+finish together in RUN: finish wins, no compression.
    drive(0, 1, 0, 0, 8'h01); tick();
    drive(0, 1, 0, 1, 8'h03);
    expect_val(S_PV, "s6_rf_pv", 32'h0);
    drain();
    tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_CNT,  "s6_rf_cnt",  32'h1);
    expect_val(S_SIG,  "s6_rf_sig",  32'h0001);
    expect_val(S_DONE, "s6_rf_done", 32'h1);
    expect_val(S_ERR,  "s6_rf_err",  32'h0);
    drain();
    // running in DONE is a protocol error.
    drive(0, 1, 0, 0, 8'h00);
    expect_val(S_PV, "s6_done_pv", 32'h0);
    drain();
    tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_ERR, "s6_done_err", 32'h1);
    drain();
    // init+finish together: init wins -> ARMED, flags cleared.
    drive(1, 0, 0, 1, '0); tick();
    drive(0, 1, 0, 0, 8'h00);
    expect_val(S_DONE, "s6_if_done", 32'h0);
    expect_val(S_ERR,  "s6_if_err",  32'h0);
    expect_val(S_PV,   "s6_if_pv",   32'h1);
    expect_val(S_PAT,  "s6_if_pat",  32'hE1);
    drain();
    tick();
    drive(0, 0, 0, 0, '0);
    expect_val(S_CNT, "s6_if_cnt", 32'h1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
